// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM states, opcode constants and IR field positions.
package mips_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_VALID = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_LSB   = 0;
  localparam int unsigned JADDR_LSB = 0;

  localparam int unsigned WORD_BYTES = 4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_ir_field_split.sv
// Combinational split of a 32-bit MIPS instruction word into its decode fields.
module ir_field_split
  import mips_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [5:0]  o_op,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_shamt,
  output logic [5:0]  o_funct,
  output logic [15:0] o_imm,
  output logic [25:0] o_jaddr
);

  assign o_op    = i_ir[OP_LSB    +: 6];
  assign o_rs    = i_ir[RS_LSB    +: 5];
  assign o_rt    = i_ir[RT_LSB    +: 5];
  assign o_rd    = i_ir[RD_LSB    +: 5];
  assign o_shamt = i_ir[SHAMT_LSB +: 5];
  assign o_funct = i_ir[FUNCT_LSB +: 6];
  assign o_imm   = i_ir[IMM_LSB   +: 16];
  assign o_jaddr = i_ir[JADDR_LSB +: 26];

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: owns PC/IR, handshakes with instruction memory, presents decoded fields.
// Optional memory timeout with sticky FetchErr when FETCH_TIMEOUT_EN is defined.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        FetchReq,
  input  logic        PCLoad,
  input  logic [31:0] PCIn,
  output logic        MemRead,
  output logic [31:0] MemAddr,
  input  logic        MemReady,
  input  logic [31:0] MemData,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [5:0]  Op,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [4:0]  Shamt,
  output logic [5:0]  Funct,
  output logic [15:0] Imm,
  output logic [25:0] JAddr,
  output logic        FetchErr
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_pend_pc;
  logic        r_pend_vld;

  logic [31:0] w_pcin_al;
  logic [31:0] w_pc_plus4;
  logic        w_capture;
  logic        w_timeout;

  assign w_pcin_al  = word_align(PCIn);
  assign w_pc_plus4 = r_pc + 32'(WORD_BYTES);
  assign w_capture  = (r_state == FS_REQ) && MemReady;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_fetch_err;

  // MemReady on the final counted edge takes priority over the timeout.
  assign w_timeout = (r_state == FS_REQ) && !MemReady &&
                     (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_tmo_cnt   <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (r_state != FS_REQ || w_next_state != FS_REQ) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  assign FetchErr = r_fetch_err;
`else
  assign w_timeout = 1'b0;
  assign FetchErr  = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= FS_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      FS_IDLE: begin
        if (FetchReq) w_next_state = FS_REQ;
      end
      FS_REQ: begin
        if (MemReady)       w_next_state = FS_VALID;
        else if (w_timeout) w_next_state = FS_IDLE;
      end
      FS_VALID: begin
        if (FetchReq) w_next_state = FS_REQ;
      end
      default: w_next_state = FS_IDLE;
    endcase
  end

  // A redirect during an in-flight read is parked in the pending register and applied at capture.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_pend_pc  <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      unique case (r_state)
        FS_REQ: begin
          if (w_capture) begin
            r_ir       <= MemData;
            r_pend_vld <= 1'b0;
            if (PCLoad)          r_pc <= w_pcin_al;
            else if (r_pend_vld) r_pc <= r_pend_pc;
            else                 r_pc <= w_pc_plus4;
          end else if (w_timeout) begin
            r_pend_vld <= 1'b0;
          end else if (PCLoad) begin
            r_pend_pc  <= w_pcin_al;
            r_pend_vld <= 1'b1;
          end
        end
        default: begin
          if (PCLoad) r_pc <= w_pcin_al;
        end
      endcase
    end
  end

  assign MemRead    = (r_state == FS_REQ);
  assign InstrValid = (r_state == FS_VALID);
  assign MemAddr    = r_pc;
  assign PC         = r_pc;
  assign PCPlus4    = w_pc_plus4;

  ir_field_split u_ir_field_split (
    .i_ir    (r_ir),
    .o_op    (Op),
    .o_rs    (Rs),
    .o_rt    (Rt),
    .o_rd    (Rd),
    .o_shamt (Shamt),
    .o_funct (Funct),
    .o_imm   (Imm),
    .o_jaddr (JAddr)
  );

endmodule
